// File: rtl/lfsr_128_seek.sv
// lfsr_128_seek: seekable 128-bit Galois LFSR challenge generator; define LFSR_SEEK_ZERO_GUARD_EN to reject all-zero seed loads
module lfsr_128_seek #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [127:0]     cmd_seed,
  output logic [127:0]     stage,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [127:0] SEED = 128'h9acbe941a5b8202ef4ed6ba07a951d19;
  localparam logic [127:0] TAPS = (128'b1 << 98) | (128'b1 << 100) | (128'b1 << 125);
  localparam logic [127:0] TAPS_R = (128'b1 << 99) | (128'b1 << 101) | (128'b1 << 126);
  typedef enum logic [1:0] {IDLE, STEP, FIN} state_t;
  state_t state;
  logic dir;
  logic [CNT_W-1:0] rem;
  logic [127:0] fwd, rev;
  logic load_ok;
  assign fwd = {stage[0], stage[127:1]} ^ (stage[0] ? TAPS : '0);
  assign rev = {stage[126:0], stage[127]} ^ (stage[127] ? TAPS_R : '0);
`ifdef LFSR_SEEK_ZERO_GUARD_EN
  assign load_ok = |cmd_seed;
`else
  assign load_ok = 1'b1;
`endif
  // command FSM: accept in IDLE, walk the LFSR one step per cycle in STEP, pulse done in FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= SEED;
      pos       <= '0;
      dir       <= 1'b0;
      rem       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          if (!cmd_op[1] && cmd_count != '0) begin
            dir   <= cmd_op[0];
            rem   <= cmd_count;
            busy  <= 1'b1;
            state <= STEP;
          end else begin
            done  <= 1'b1;
            state <= FIN;
            if (cmd_op[1] && (cmd_op[0] || load_ok)) begin
              stage <= cmd_op[0] ? SEED : cmd_seed;
              pos   <= '0;
              err   <= 1'b0;
            end else if (cmd_op[1]) begin
              err <= 1'b1;
            end
          end
        end
        STEP: begin
          stage <= dir ? rev : fwd;
          pos   <= dir ? pos - POS_W'(1) : pos + POS_W'(1);
          rem   <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
